fft_ctrl_seq: RTL and testbench
===============================

Name: fft_ctrl_seq

Overview:
- In-place radix-2 FFT sequencer that drives the stage / pair_id inputs of the AGU and issues read/write strobes to the sample memory.
- Walks LOG2N stages × N/2 butterfly pairs per transform.
- Inserts a drain gap between stages so no stage reads data the previous stage has not yet written back.
- Tracks in-flight butterflies through a delay line matching butterfly pipeline depth; sits between the top-level start/done interface and AGU + butterfly datapath.

Parameters:
- N, 32, FFT size (power of two, ≥4); LOG2N = $clog2(N).
- BF_LATENCY, 3, cycles from issue (rd_en) to write-back (wr_en) through AGU + memory read + butterfly; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin transform; sampled only in IDLE
- stage  out  LOG2N  stage index to AGU
- pair_id  out  LOG2N-1  pair index to AGU
- rd_en  out  1  issue strobe: pair (stage, pair_id) is read this cycle
- wr_en  out  1  write-back strobe for a completed butterfly
- wr_stage  out  LOG2N  stage of butterfly being written
- wr_pair_id  out  LOG2N-1  pair of butterfly being written
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse, transform complete

Behaviour:
- Reset values:
  - state=IDLE; stage=0, pair_id=0.
  - rd_en, wr_en, busy, done = 0.
  - wr_stage=0, wr_pair_id=0; delay line cleared (all valids 0).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN next cycle, with stage=0, pair_id=0.
  - start=0 → hold.
- RUN:
  - rd_en=1 every cycle.
  - pair_id increments each cycle; at pair_id=N/2-1 → DRAIN, with pair_id wrapping to 0.
- DRAIN:
  - rd_en=0 for exactly BF_LATENCY cycles (counter).
  - On the last drain cycle: if stage<LOG2N-1 then stage+1 and → RUN; else → DONE.
- DONE:
  - done=1 and busy=0 for one cycle.
  - stage resets to 0; → IDLE.
- Write-back path:
  - Delay line of depth BF_LATENCY carries {rd_en, stage, pair_id}.
  - wr_en / wr_stage / wr_pair_id equal the issue values exactly BF_LATENCY cycles later.
  - The last write of each stage lands in that stage's final DRAIN cycle; the next stage's first read follows on the next cycle.
- Timing: cycles from first RUN cycle to done = LOG2N·(N/2+BF_LATENCY). For N=32, BF_LATENCY=3 this is 95.
- start while busy or in DONE: ignored, with no queuing.
- start held high continuously: a new transform begins the cycle after DONE returns to IDLE.
- Reset mid-operation:
  - Takes effect next edge: IDLE, outputs to reset values.
  - Delay line flushed; no wr_en after reset.
- Widths: counters wrap naturally at their field width; compare against N/2-1 and LOG2N-1 explicitly.

Optional Feature:
- Macro: FFT_CTRL_PERF_EN.
- Defined:
  - Extra output cycle_count [15:0]; cleared when leaving IDLE; increments every busy cycle; holds its value after done until the next start.
  - Extra output xform_count [15:0]; increments on each done, wraps at 2^16.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour identical.

Decomposition:
- Shared package fft_pkg:
  - constants N, LOG2N, BF_LATENCY defaults;
  - state enum (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - stage_t / pair_t width typedefs shared with AGU.
- One sub-module: fft_ctrl_delay, a parameterised shift register (depth BF_LATENCY, width 1+LOG2N+LOG2N-1) with synchronous clear on rst.

Test Plan:
- Reset then start pulse (N=32, L=3):
  - rd_en high cycles 0–15 with pair_id 0..15 and stage=0; rd_en low cycles 16–18;
  - stage=1, pair_id=0 at cycle 19;
  - done pulse at cycle 95, busy low from cycle 95.
- Write-back check: every wr_en occurs exactly 3 cycles after the matching rd_en with the same stage/pair_id; 80 wr_en total; none after done.
- start asserted at cycles 5 and 40 during a transform: no effect; done still at cycle 95 with a single pulse.
- rst asserted at cycle 30 for 1 cycle:
  - next cycle busy=0, rd_en=0, wr_en=0, stage=0;
  - no wr_en in the following 3 cycles;
  - a new start then runs a full 95-cycle transform.
- start held high: back-to-back transforms; second first-RUN cycle is 2 cycles after first done (DONE→IDLE→RUN); stage restarts at 0.
- FFT_CTRL_PERF_EN: after one transform cycle_count=95 and xform_count=1; after a second, xform_count=2.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT control slice: default transform geometry,
// the sequencer state encoding, and the stage / pair index types the AGU uses.
package fft_pkg;

    localparam int FFT_N          = 32;
    localparam int FFT_LOG2N      = $clog2(FFT_N);
    localparam int FFT_BF_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [FFT_LOG2N-1:0] stage_t;
    typedef logic [FFT_LOG2N-2:0] pair_t;

endpackage

// File: rtl/fft_ctrl_delay.sv
// Fixed-depth shift register that follows each issued butterfly through the
// AGU + memory + butterfly pipeline, so write-back strobes line up with data.
module fft_ctrl_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift one tap per cycle; a reset flushes every in-flight entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is cleared on reset on purpose - each tap carries
            // a valid bit, and a stale one would emit a spurious write-back.
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_ctrl_seq.sv
// In-place radix-2 FFT sequencer: walks LOG2N stages of N/2 butterfly pairs,
// leaves a BF_LATENCY-cycle drain gap between stages, and delays each issue
// to produce the matching write-back strobe.
// Optional performance counters are built when FFT_CTRL_PERF_EN is defined.
module fft_ctrl_seq
    import fft_pkg::*;
#(
    parameter  int N          = FFT_N,
    parameter  int BF_LATENCY = FFT_BF_LATENCY,
    localparam int LOG2N      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [LOG2N-1:0] stage,
    output logic [LOG2N-2:0] pair_id,
    output logic             rd_en,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_stage,
    output logic [LOG2N-2:0] wr_pair_id,
    output logic             busy,
    output logic             done
`ifdef FFT_CTRL_PERF_EN
    ,
    output logic [15:0]      cycle_count,
    output logic [15:0]      xform_count
`endif
);

    localparam int DW  = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam int DLW = 1 + LOG2N + (LOG2N - 1);

    localparam logic [LOG2N-2:0] PAIR_LAST  = (LOG2N-1)'(N/2 - 1);
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(BF_LATENCY - 1);

    state_t           state;
    logic [DW-1:0]    drain_cnt;
    logic [DLW-1:0]   wb_word;

    // Sequencer FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            pair_id   <= '0;
            drain_cnt <= '0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of stage / pair_id / drain_cnt.
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        stage   <= '0;
                        pair_id <= '0;
                        rd_en   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (pair_id == PAIR_LAST) begin
                        state     <= DRAIN;
                        pair_id   <= '0;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        pair_id <= pair_id + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        if (stage < STAGE_LAST) begin
                            state <= RUN;
                            stage <= stage + 1'b1;
                            rd_en <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    stage <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fft_ctrl_delay #(
        .DEPTH (BF_LATENCY),
        .WIDTH (DLW)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, stage, pair_id}),
        .dout (wb_word)
    );

    assign {wr_en, wr_stage, wr_pair_id} = wb_word;

`ifdef FFT_CTRL_PERF_EN
    // Cycle count restarts on each accepted start; transform count wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            xform_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                cycle_count <= '0;
            end else if (busy) begin
                cycle_count <= cycle_count + 16'd1;
            end
            if (done) begin
                xform_count <= xform_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_ctrl_seq.sv
// Self-checking bench for fft_ctrl_seq (N=32, BF_LATENCY=3): a table of
// per-cycle expectations for a full transform, a write-back scoreboard, and
// hand-written sequences for start-ignore, mid-run reset and held start.
module tb_fft_ctrl_seq;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] stage;
    logic [3:0] pair_id;
    logic       rd_en;
    logic       wr_en;
    logic [4:0] wr_stage;
    logic [3:0] wr_pair_id;
    logic       busy;
    logic       done;
`ifdef FFT_CTRL_PERF_EN
    logic [15:0] cycle_count;
    logic [15:0] xform_count;
`endif

    fft_ctrl_seq #(.N(32), .BF_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stage      (stage),
        .pair_id    (pair_id),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .wr_stage   (wr_stage),
        .wr_pair_id (wr_pair_id),
        .busy       (busy),
        .done       (done)
`ifdef FFT_CTRL_PERF_EN
        ,
        .cycle_count(cycle_count),
        .xform_count(xform_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int gcyc  = 0;
    int wr_total = 0;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write-back scoreboard: each issue pushes its expected write-back.
    typedef struct {
        logic [4:0] stage;
        logic [3:0] pair;
        int         due;
    } sb_t;
    sb_t sb[$];
    sb_t sb_e;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_total++;
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                check("wr_stage", wr_stage, sb_e.stage);
                check("wr_pair_id", wr_pair_id, sb_e.pair);
                check("wr_latency", gcyc, sb_e.due);
            end
        end
        if (rst === 1'b1) begin
            sb.delete();
        end else if (rd_en === 1'b1) begin
            sb.push_back('{stage, pair_id, gcyc + LAT});
        end
    end

    // Per-cycle expectations, cycle 0 = first RUN cycle.
    typedef struct {
        int         cyc;
        logic       rd_en;
        logic [4:0] stage;
        logic [3:0] pair;
        logic       busy;
        logic       done;
        logic       wr_en;
        logic [4:0] wr_stage;
        logic [3:0] wr_pair;
        logic       chk_pos;
    } vec_t;
    localparam int NV = 17;
    vec_t vt[NV];

    task automatic run_checked(input bit glitch);
        int done_cnt;
        int done_at;
        int wr0;
        done_cnt = 0;
        done_at  = -1;
        wr0      = wr_total;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int rel = 0; rel <= 97; rel++) begin
            start = glitch && (rel == 5 || rel == 40);
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = rel;
            end
            for (int k = 0; k < NV; k++) begin
                if (vt[k].cyc == rel) begin
                    check($sformatf("rd_en@%0d", rel), rd_en, vt[k].rd_en);
                    check($sformatf("busy@%0d", rel), busy, vt[k].busy);
                    check($sformatf("done@%0d", rel), done, vt[k].done);
                    check($sformatf("wr_en@%0d", rel), wr_en, vt[k].wr_en);
                    if (vt[k].chk_pos) begin
                        check($sformatf("stage@%0d", rel), stage, vt[k].stage);
                        check($sformatf("pair_id@%0d", rel), pair_id, vt[k].pair);
                    end
                    if (vt[k].wr_en) begin
                        check($sformatf("wr_stage@%0d", rel), wr_stage, vt[k].wr_stage);
                        check($sformatf("wr_pair_id@%0d", rel), wr_pair_id, vt[k].wr_pair);
                    end
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_cycle", done_at, 95);
        check("done_pulses", done_cnt, 1);
        check("wr_count", wr_total - wr0, 80);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1;
        int t0;
        bit seen;

        vt[0]  = '{0,  1, 0, 0,  1, 0, 0, 0, 0,  1};
        vt[1]  = '{1,  1, 0, 1,  1, 0, 0, 0, 0,  1};
        vt[2]  = '{3,  1, 0, 3,  1, 0, 1, 0, 0,  1};
        vt[3]  = '{15, 1, 0, 15, 1, 0, 1, 0, 12, 1};
        vt[4]  = '{16, 0, 0, 0,  1, 0, 1, 0, 13, 1};
        vt[5]  = '{18, 0, 0, 0,  1, 0, 1, 0, 15, 1};
        vt[6]  = '{19, 1, 1, 0,  1, 0, 0, 0, 0,  1};
        vt[7]  = '{22, 1, 1, 3,  1, 0, 1, 1, 0,  1};
        vt[8]  = '{37, 0, 1, 0,  1, 0, 1, 1, 15, 1};
        vt[9]  = '{38, 1, 2, 0,  1, 0, 0, 0, 0,  1};
        vt[10] = '{57, 1, 3, 0,  1, 0, 0, 0, 0,  1};
        vt[11] = '{76, 1, 4, 0,  1, 0, 0, 0, 0,  1};
        vt[12] = '{91, 1, 4, 15, 1, 0, 1, 4, 12, 1};
        vt[13] = '{92, 0, 4, 0,  1, 0, 1, 4, 13, 1};
        vt[14] = '{94, 0, 4, 0,  1, 0, 1, 4, 15, 1};
        vt[15] = '{95, 0, 0, 0,  0, 1, 0, 0, 0,  0};
        vt[16] = '{96, 0, 0, 0,  0, 0, 0, 0, 0,  1};

        // Reset state
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stage", stage, 0);
        check("rst_pair_id", pair_id, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_stage", wr_stage, 0);
        check("rst_wr_pair_id", wr_pair_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef FFT_CTRL_PERF_EN
        check("rst_cycle_count", cycle_count, 0);
        check("rst_xform_count", xform_count, 0);
`endif
        @(posedge clk); #1;

        // Plain transform
        run_checked(1'b0);
`ifdef FFT_CTRL_PERF_EN
        check("perf1_cycle_count", cycle_count, 95);
        check("perf1_xform_count", xform_count, 1);
`endif

        // Start pulses during a transform are ignored
        run_checked(1'b1);
`ifdef FFT_CTRL_PERF_EN
        check("perf2_cycle_count", cycle_count, 95);
        check("perf2_xform_count", xform_count, 2);
`endif

        // Reset in the middle of a transform
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_stage", stage, 0);
        check("mid_rst_done", done, 0);
`ifdef FFT_CTRL_PERF_EN
        check("mid_rst_xform_count", xform_count, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_rst_wr_en+%0d", i), wr_en, 0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        run_checked(1'b0);

        // Start held high: back-to-back transforms
        start = 1'b1;
        d1 = -1;
        for (int i = 0; i < 200 && d1 < 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) d1 = gcyc;
            @(posedge clk); #1;
        end
        check("held_first_done_seen", (d1 >= 0), 1);
        t0 = -1;
        for (int i = 0; i < 10 && t0 < 0; i++) begin
            @(negedge clk);
            if (rd_en === 1'b1) begin
                t0 = gcyc;
                check("held_restart_stage", stage, 0);
                check("held_restart_pair_id", pair_id, 0);
            end
            @(posedge clk); #1;
        end
        check("held_restart_gap", t0 - d1, 2);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                check("held_second_duration", gcyc - t0, 95);
            end
            @(posedge clk); #1;
        end
        check("held_second_done_seen", seen, 1);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("held_end_busy", busy, 0);
        check("held_end_rd_en", rd_en, 0);
        check("held_end_sb_empty", sb.size(), 0);
`ifdef FFT_CTRL_PERF_EN
        check("held_cycle_count", cycle_count, 95);
        check("held_xform_count", xform_count, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
